// File: rtl/ama_riscv_mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between icache fills and dcache fills/writebacks.
// One transaction in flight at a time; exposes saturating grant counters and a sticky unexpected-response flag.
module ama_riscv_mem_arbiter #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_rsp_valid,
  output logic [LINE_W-1:0] ic_rsp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_we,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_rsp_valid,
  output logic [LINE_W-1:0] dc_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]  ic_grant_cnt,
  output logic [CNT_W-1:0]  dc_grant_cnt,
  output logic              err_unexp_rsp
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

  state_t            state;
  logic              last_dc;
  logic              own_dc;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [LINE_W-1:0] own_wdata;
  logic              grant_ic;
  logic              grant_dc;
  logic              rsp_fire;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_ic = 1'b0;
    grant_dc = 1'b0;
    if (state == ST_IDLE && !rst) begin
      if (ic_req_valid && dc_req_valid) begin
        grant_dc = !last_dc;
        grant_ic = last_dc;
      end else begin
        grant_dc = dc_req_valid;
        grant_ic = ic_req_valid;
      end
    end
  end

  assign ic_req_ready  = grant_ic;
  assign dc_req_ready  = grant_dc;

  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = own_addr;
  assign mem_req_we    = own_we;
  assign mem_req_wdata = own_wdata;

  assign rsp_fire      = (state == ST_RSP) && mem_rsp_valid;
  assign ic_rsp_valid  = rsp_fire && !own_dc;
  assign ic_rsp_data   = ic_rsp_valid ? mem_rsp_data : '0;
  assign dc_rsp_valid  = rsp_fire && own_dc;
  assign dc_rsp_data   = (dc_rsp_valid && !own_we) ? mem_rsp_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_dc       <= 1'b0;
      own_dc        <= 1'b0;
      own_we        <= 1'b0;
      own_addr      <= '0;
      own_wdata     <= '0;
      ic_grant_cnt  <= '0;
      dc_grant_cnt  <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (mem_rsp_valid && state != ST_RSP) begin
        err_unexp_rsp <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (grant_ic || grant_dc) begin
            own_dc    <= grant_dc;
            own_addr  <= grant_dc ? dc_req_addr : ic_req_addr;
            own_we    <= grant_dc && dc_req_we;
            own_wdata <= grant_dc ? dc_req_wdata : '0;
            last_dc   <= grant_dc;
            if (grant_dc) begin
              if (dc_grant_cnt != '1) dc_grant_cnt <= dc_grant_cnt + CNT_W'(1);
            end else begin
              if (ic_grant_cnt != '1) ic_grant_cnt <= ic_grant_cnt + CNT_W'(1);
            end
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_req_ready) state <= ST_RSP;
        end
        ST_RSP: begin
          if (mem_rsp_valid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses/memory requests, a negedge monitor pops and compares.
// The reference keeps a line-granular memory image and the round-robin rule as plain bench state.
module tb_ama_riscv_mem_arbiter;
  localparam int AW = 26;
  localparam int LW = 128;
  localparam int CW = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic          we;
    logic [LW-1:0] d;
  } mreq_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [LW-1:0] ic_rsp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_we, dc_rsp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_req_wdata, dc_rsp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata, mem_rsp_data;
  logic [CW-1:0] ic_grant_cnt, dc_grant_cnt;
  logic          err_unexp_rsp;

  ama_riscv_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_we(dc_req_we), .dc_req_wdata(dc_req_wdata),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference memory image (updated when a writeback is accepted) and the bench's backing memory.
  logic [LW-1:0] mdl_mem  [logic [AW-1:0]];
  logic [LW-1:0] phys_mem [logic [AW-1:0]];

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1;
    return {w, ~w, w ^ 32'h1234_5678, 32'(a)};
  endfunction

  function automatic logic [LW-1:0] mdl_rd(input logic [AW-1:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [LW-1:0] phys_rd(input logic [AW-1:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [LW-1:0] exp_ic_q[$];
  logic [LW-1:0] exp_dc_q[$];
  mreq_t         exp_mem_q[$];

  // ---------------- monitor ----------------
  bit        grant_log[$];
  longint    grant_t[$];
  bit        m_last_dc;
  int        m_ic_cnt, m_dc_cnt, outst;
  bit        prev_stall;
  mreq_t     prev_req, cur_req, e_req;
  logic [LW-1:0] e_line;
  bit        exp_dc_win;

  always @(negedge clk) begin
    if (rst) begin
      exp_ic_q.delete(); exp_dc_q.delete(); exp_mem_q.delete();
      grant_log.delete(); grant_t.delete();
      m_last_dc = 1'b0; m_ic_cnt = 0; m_dc_cnt = 0; outst = 0; prev_stall = 1'b0;
    end else begin
      if (ic_req_ready || dc_req_ready) begin
        exp_dc_win = dc_req_valid && (!ic_req_valid || !m_last_dc);
        chk(outst == 0, "grant_while_busy", 160'(outst), 160'(0));
        chk(dc_req_ready == exp_dc_win, "arb_dc_ready", 160'(dc_req_ready), 160'(exp_dc_win));
        chk(ic_req_ready == (ic_req_valid && !exp_dc_win), "arb_ic_ready",
            160'(ic_req_ready), 160'(ic_req_valid && !exp_dc_win));
        m_last_dc = dc_req_ready;
        grant_log.push_back(dc_req_ready);
        grant_t.push_back(longint'($time));
        if (dc_req_ready) m_dc_cnt = (m_dc_cnt == 2**CW-1) ? m_dc_cnt : m_dc_cnt + 1;
        else              m_ic_cnt = (m_ic_cnt == 2**CW-1) ? m_ic_cnt : m_ic_cnt + 1;
        outst++;
      end
      if (mem_req_valid) begin
        cur_req = '{a: mem_req_addr, we: mem_req_we, d: mem_req_wdata};
        if (prev_stall) chk(cur_req == prev_req, "mem_req_stable", 160'(cur_req), 160'(prev_req));
        if (mem_req_ready) begin
          chk(exp_mem_q.size() != 0, "mem_req_expected", 160'(exp_mem_q.size()), 160'(1));
          if (exp_mem_q.size() != 0) begin
            e_req = exp_mem_q.pop_front();
            chk(cur_req == e_req, "mem_req_fields", 160'(cur_req), 160'(e_req));
          end
        end
        prev_stall = !mem_req_ready;
        prev_req   = cur_req;
      end else begin
        prev_stall = 1'b0;
      end
      if (ic_rsp_valid) begin
        chk(exp_ic_q.size() != 0, "ic_rsp_expected", 160'(exp_ic_q.size()), 160'(1));
        if (exp_ic_q.size() != 0) begin
          e_line = exp_ic_q.pop_front();
          chk(ic_rsp_data == e_line, "ic_rsp_data", 160'(ic_rsp_data), 160'(e_line));
        end
        outst--;
      end
      if (dc_rsp_valid) begin
        chk(exp_dc_q.size() != 0, "dc_rsp_expected", 160'(exp_dc_q.size()), 160'(1));
        if (exp_dc_q.size() != 0) begin
          e_line = exp_dc_q.pop_front();
          chk(dc_rsp_data == e_line, "dc_rsp_data", 160'(dc_rsp_data), 160'(e_line));
        end
        outst--;
      end
    end
  end

  // ---------------- stimulus agents ----------------
  bit            ic_out, dc_out, mem_pend, pend_we;
  logic [AW-1:0] pend_addr;
  int            rsp_wait, req_wait, mreq_cycles, n_ic_rsp;
  int            rdy_pct, rdy_hold, rsp_max;
  bit            noise, rnd, ic_auto, dc_auto, mem_auto;
  longint        ic_acc_t, ic_rsp_t;
  logic [LW-1:0] last_ic_rsp, last_dc_rsp;

  task automatic step();
    bit ic_hs, dc_hs, mem_hs;
    @(negedge clk);
    ic_hs  = ic_req_valid && ic_req_ready;
    dc_hs  = dc_req_valid && dc_req_ready;
    mem_hs = mem_req_valid && mem_req_ready;
    if (mem_req_valid) mreq_cycles++;
    if (ic_hs) begin
      exp_ic_q.push_back(mdl_rd(ic_req_addr));
      exp_mem_q.push_back('{a: ic_req_addr, we: 1'b0, d: '0});
      ic_out = 1'b1; ic_acc_t = longint'($time);
    end
    if (dc_hs) begin
      if (dc_req_we) begin
        mdl_mem[dc_req_addr] = dc_req_wdata;
        exp_dc_q.push_back('0);
      end else begin
        exp_dc_q.push_back(mdl_rd(dc_req_addr));
      end
      exp_mem_q.push_back('{a: dc_req_addr, we: dc_req_we, d: dc_req_wdata});
      dc_out = 1'b1;
    end
    if (ic_rsp_valid) begin ic_out = 1'b0; ic_rsp_t = longint'($time); n_ic_rsp++; last_ic_rsp = ic_rsp_data; end
    if (dc_rsp_valid) begin dc_out = 1'b0; last_dc_rsp = dc_rsp_data; end
    if (mem_hs) begin
      if (mem_req_we) phys_mem[mem_req_addr] = mem_req_wdata;
      mem_pend = 1'b1; pend_addr = mem_req_addr; pend_we = mem_req_we;
      rsp_wait = $urandom_range(0, rsp_max);
    end
    @(posedge clk); #1;
    if (ic_hs) ic_req_valid = 1'b0;
    if (dc_hs) dc_req_valid = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    if (mem_pend && mem_auto) begin
      if (rsp_wait == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = pend_we ? rand_line() : phys_rd(pend_addr);
        mem_pend      = 1'b0;
      end else begin
        rsp_wait--;
      end
    end
    if (mem_req_valid) begin
      if (req_wait < rdy_hold) begin mem_req_ready = 1'b0; req_wait++; end
      else mem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    end else begin
      req_wait = 0;
      mem_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (!ic_req_valid && !ic_out && (ic_auto || (rnd && $urandom_range(0, 99) < 30))) begin
      ic_req_valid = 1'b1; ic_req_addr = AW'($urandom_range(0, 31));
    end else if (rnd && ic_req_valid && $urandom_range(0, 99) < 4) begin
      ic_req_valid = 1'b0;
    end
    if (!dc_req_valid && !dc_out && (dc_auto || (rnd && $urandom_range(0, 99) < 30))) begin
      dc_req_valid = 1'b1; dc_req_addr = AW'(32 + $urandom_range(0, 31));
      dc_req_we = rnd ? 1'($urandom_range(0, 1)) : 1'b0; dc_req_wdata = rand_line();
    end else if (rnd && dc_req_valid && $urandom_range(0, 99) < 4) begin
      dc_req_valid = 1'b0;
    end
  endtask

  task automatic run_until_idle(input int max, input string nm);
    int n = 0;
    while ((ic_req_valid || dc_req_valid || ic_out || dc_out || mem_pend) && n < max) begin
      step(); n++;
    end
    chk(n < max, nm, 160'(n), 160'(max));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    ic_out = 1'b0; dc_out = 1'b0; mem_pend = 1'b0; req_wait = 0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rsp0;
    rst = 1'b1;
    ic_req_valid = 1'b1; ic_req_addr = '0; dc_req_valid = 1'b1; dc_req_addr = '0;
    dc_req_we = 1'b0; dc_req_wdata = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    ic_out = 0; dc_out = 0; mem_pend = 0; pend_we = 0; pend_addr = '0; rsp_wait = 0; req_wait = 0;
    mreq_cycles = 0; n_ic_rsp = 0; rdy_pct = 100; rdy_hold = 0; rsp_max = 0;
    noise = 0; rnd = 0; ic_auto = 0; dc_auto = 0; mem_auto = 1;
    repeat (3) @(posedge clk);
    #1;
    chk(ic_req_ready == 1'b0 && dc_req_ready == 1'b0, "rst_ready", 160'({ic_req_ready, dc_req_ready}), 160'(0));
    chk(mem_req_valid == 1'b0, "rst_mem_req_valid", 160'(mem_req_valid), 160'(0));
    chk(ic_rsp_valid == 1'b0 && dc_rsp_valid == 1'b0, "rst_rsp_valid", 160'({ic_rsp_valid, dc_rsp_valid}), 160'(0));
    chk(mem_req_addr == '0 && mem_req_wdata == '0 && mem_req_we == 1'b0, "rst_mem_fields",
        160'({mem_req_addr, mem_req_we, mem_req_wdata}), 160'(0));
    chk(ic_grant_cnt == '0 && dc_grant_cnt == '0, "rst_counters", 160'({ic_grant_cnt, dc_grant_cnt}), 160'(0));
    chk(err_unexp_rsp == 1'b0, "rst_err", 160'(err_unexp_rsp), 160'(0));
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    rst = 1'b0;

    // IC-only fill with an immediate memory handshake.
    mdl_mem[AW'(26'h100)]  = {16{8'hA5}};
    phys_mem[AW'(26'h100)] = {16{8'hA5}};
    ic_req_valid = 1'b1; ic_req_addr = AW'(26'h100);
    #1;
    chk(ic_req_ready == 1'b1 && dc_req_ready == 1'b0, "ic_only_ready", 160'({ic_req_ready, dc_req_ready}), 160'(2));
    run_until_idle(20, "ic_only_timeout");
    chk(ic_rsp_t - ic_acc_t == 20, "ic_only_latency", 160'(ic_rsp_t - ic_acc_t), 160'(20));
    chk(last_ic_rsp == {16{8'hA5}}, "ic_only_data", 160'(last_ic_rsp), 160'({16{8'hA5}}));
    chk(ic_grant_cnt == 1 && dc_grant_cnt == 0, "ic_only_cnt", 160'({ic_grant_cnt, dc_grant_cnt}), 160'(8'h10));

    // Both continuously valid: strict alternation starting with DC after reset.
    do_reset();
    ic_auto = 1; dc_auto = 1;
    n = 0;
    while (grant_log.size() < 9 && n < 200) begin step(); n++; end
    ic_auto = 0; dc_auto = 0;
    run_until_idle(50, "fair_timeout");
    chk(grant_log.size() == 10, "fair_grants", 160'(grant_log.size()), 160'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size())
        chk(grant_log[i] == (i % 2 == 0), $sformatf("fair_order_%0d", i), 160'(grant_log[i]), 160'(i % 2 == 0));
    end
    if (grant_t.size() >= 2)
      chk(grant_t[1] - grant_t[0] == 30, "back_to_back", 160'(grant_t[1] - grant_t[0]), 160'(30));
    chk(ic_grant_cnt == 5 && dc_grant_cnt == 5, "fair_cnt", 160'({ic_grant_cnt, dc_grant_cnt}), 160'(8'h55));

    // DC writeback with memory stalling the request for five cycles.
    rdy_hold = 5; mreq_cycles = 0;
    dc_req_valid = 1'b1; dc_req_addr = AW'(26'h30); dc_req_we = 1'b1; dc_req_wdata = {4{32'hDEAD_BEEF}};
    run_until_idle(30, "wb_timeout");
    chk(mreq_cycles == 6, "wb_req_cycles", 160'(mreq_cycles), 160'(6));
    chk(last_dc_rsp == '0, "wb_ack_data", 160'(last_dc_rsp), 160'(0));
    chk(phys_rd(AW'(26'h30)) == {4{32'hDEAD_BEEF}}, "wb_mem_data", 160'(phys_rd(AW'(26'h30))), 160'({4{32'hDEAD_BEEF}}));
    chk(err_unexp_rsp == 1'b0, "err_still_clear", 160'(err_unexp_rsp), 160'(0));
    rdy_hold = 0;

    // Unexpected memory response while idle.
    mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'hCAFE_F00D}};
    #1;
    chk(ic_rsp_valid == 1'b0 && dc_rsp_valid == 1'b0, "unexp_no_rsp", 160'({ic_rsp_valid, dc_rsp_valid}), 160'(0));
    step();
    chk(err_unexp_rsp == 1'b1, "unexp_err_set", 160'(err_unexp_rsp), 160'(1));
    ic_req_valid = 1'b1; ic_req_addr = AW'(26'h10);
    run_until_idle(20, "unexp_follow_timeout");
    chk(err_unexp_rsp == 1'b1, "unexp_err_sticky", 160'(err_unexp_rsp), 160'(1));

    // Reset asserted while the response is being delivered.
    mem_auto = 0;
    ic_req_valid = 1'b1; ic_req_addr = AW'(26'h15);
    n = 0;
    while (!mem_pend && n < 20) begin step(); n++; end
    chk(mem_pend, "rstmid_reach_rsp", 160'(mem_pend), 160'(1));
    mem_rsp_valid = 1'b1; mem_rsp_data = {4{32'h0BAD_0BAD}};
    #1;
    chk(ic_rsp_valid == 1'b1, "rstmid_rsp_before", 160'(ic_rsp_valid), 160'(1));
    #1 rst = 1'b1;
    #1;
    chk(ic_rsp_valid == 1'b0 && dc_rsp_valid == 1'b0 && mem_req_valid == 1'b0, "rstmid_outputs",
        160'({ic_rsp_valid, dc_rsp_valid, mem_req_valid}), 160'(0));
    chk(ic_grant_cnt == '0 && dc_grant_cnt == '0 && err_unexp_rsp == 1'b0, "rstmid_regs",
        160'({ic_grant_cnt, dc_grant_cnt, err_unexp_rsp}), 160'(0));
    mem_rsp_valid = 1'b0; ic_req_valid = 1'b0; mem_pend = 1'b0; ic_out = 1'b0; dc_out = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0; mem_auto = 1;
    rsp0 = n_ic_rsp;
    ic_req_valid = 1'b1; ic_req_addr = AW'(26'h16);
    run_until_idle(20, "rstmid_fresh_timeout");
    chk(n_ic_rsp - rsp0 == 1, "rstmid_fresh_rsp", 160'(n_ic_rsp - rsp0), 160'(1));
    chk(ic_grant_cnt == 1 && dc_grant_cnt == 0, "rstmid_fresh_cnt", 160'({ic_grant_cnt, dc_grant_cnt}), 160'(8'h10));

    // Randomized traffic: stalls, variable response delay, dropped requests, ignored ready noise.
    rnd = 1; rdy_pct = 60; rsp_max = 3; noise = 1;
    repeat (1500) step();
    rnd = 0; noise = 0;
    run_until_idle(100, "random_drain_timeout");
    chk(ic_grant_cnt == CW'(m_ic_cnt), "random_ic_cnt", 160'(ic_grant_cnt), 160'(m_ic_cnt));
    chk(dc_grant_cnt == CW'(m_dc_cnt), "random_dc_cnt", 160'(dc_grant_cnt), 160'(m_dc_cnt));
    chk(ic_grant_cnt == '1 && dc_grant_cnt == '1, "random_cnt_saturated", 160'({ic_grant_cnt, dc_grant_cnt}), 160'(8'hFF));
    chk(exp_ic_q.size() + exp_dc_q.size() + exp_mem_q.size() == 0, "random_queues_empty",
        160'(exp_ic_q.size() + exp_dc_q.size() + exp_mem_q.size()), 160'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
